// File: rtl/memwb_retire_latch.sv
// -----------------------------------------------------------------------------
// memwb_retire_latch
//
// MEM/WB pipeline latch that also acts as the retirement point of the core.
// It captures the EX/MEM record, tells the rest of the machine when the held
// instruction retires, counts retired instructions, and freezes once a halt
// instruction has retired.
//
// Ports
//   CLK, nRST             clock (rising edge) and asynchronous active-low reset
//   en                    1 = load the EX/MEM record this edge, 0 = hold (stall)
//   flush                 1 = replace the latch contents with a bubble
//   in_valid              the EX/MEM record holds a real instruction
//   in_* / out_*          EX/MEM record words and their registered copies
//   out_valid             the latch holds a real instruction
//   commit                the held instruction retires this cycle
//   rf_wen                register-file write enable (never for x0)
//   trk_stall             trace-monitor stall indication (~commit)
//   retire_count          retired-instruction counter, wraps modulo 2^CNT_W
//   halted                sticky: a halt instruction has retired
// -----------------------------------------------------------------------------
module memwb_retire_latch #(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_next_pc,
    input  logic [31:0]      in_target_pc,
    input  logic [31:0]      in_imm32,
    input  logic [31:0]      in_wdat,
    input  logic [31:0]      in_dmem_addr,
    input  logic [31:0]      in_dmem_store,
    input  logic [4:0]       in_rsel1,
    input  logic [4:0]       in_rsel2,
    input  logic [4:0]       in_wsel,
    input  logic             in_regwrite,
    input  logic             in_halt,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_next_pc,
    output logic [31:0]      out_target_pc,
    output logic [31:0]      out_imm32,
    output logic [31:0]      out_wdat,
    output logic [31:0]      out_dmem_addr,
    output logic [31:0]      out_dmem_store,
    output logic [4:0]       out_rsel1,
    output logic [4:0]       out_rsel2,
    output logic [4:0]       out_wsel,
    output logic             out_regwrite,
    output logic             out_halt,
    output logic             out_valid,
    output logic             commit,
    output logic             rf_wen,
    output logic             trk_stall,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] target_pc;
        logic [31:0] imm32;
        logic [31:0] wdat;
        logic [31:0] dmem_addr;
        logic [31:0] dmem_store;
        logic [4:0]  rsel1;
        logic [4:0]  rsel2;
        logic [4:0]  wsel;
        logic        regwrite;
        logic        halt;
    } rec_t;

    rec_t             rec_q, rec_d;
    rec_t             in_rec;
    rec_t             bubble_rec;
    logic             valid_q, valid_d;
    logic             fresh_q, fresh_d;   // record arrived on the last edge
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             commit_w;

    always_comb begin
        in_rec = '{instr: in_instr, pc: in_pc, next_pc: in_next_pc,
                   target_pc: in_target_pc, imm32: in_imm32, wdat: in_wdat,
                   dmem_addr: in_dmem_addr, dmem_store: in_dmem_store,
                   rsel1: in_rsel1, rsel2: in_rsel2, wsel: in_wsel,
                   regwrite: in_regwrite, halt: in_halt};
        bubble_rec       = '0;
        bubble_rec.instr = BUBBLE_INSTR;
    end

    // A record retires only in the cycle right after it was loaded, so a long
    // stall cannot make the same instruction retire twice.
    assign commit_w = valid_q & fresh_q & ~halted_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        rec_d    = rec_q;
        valid_d  = valid_q;
        fresh_d  = 1'b0;
        halted_d = halted_q;
        count_d  = count_q;

        if (commit_w) begin
            count_d = count_q + CNT_W'(1);
            if (rec_q.halt) begin
                halted_d = 1'b1;
            end
        end

        if (halted_q) begin
            // Frozen: en and flush are ignored until reset.
            fresh_d = fresh_q;
        end else if (flush) begin
            rec_d   = bubble_rec;
            valid_d = 1'b0;
        end else if (en) begin
            if (in_valid) begin
                rec_d   = in_rec;
                valid_d = 1'b1;
                fresh_d = 1'b1;
            end else begin
                rec_d   = bubble_rec;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rec_q    <= bubble_rec;
            valid_q  <= 1'b0;
            fresh_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            rec_q    <= rec_d;
            valid_q  <= valid_d;
            fresh_q  <= fresh_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign out_instr      = rec_q.instr;
    assign out_pc         = rec_q.pc;
    assign out_next_pc    = rec_q.next_pc;
    assign out_target_pc  = rec_q.target_pc;
    assign out_imm32      = rec_q.imm32;
    assign out_wdat       = rec_q.wdat;
    assign out_dmem_addr  = rec_q.dmem_addr;
    assign out_dmem_store = rec_q.dmem_store;
    assign out_rsel1      = rec_q.rsel1;
    assign out_rsel2      = rec_q.rsel2;
    assign out_wsel       = rec_q.wsel;
    assign out_regwrite   = rec_q.regwrite;
    assign out_halt       = rec_q.halt;
    assign out_valid      = valid_q;
    assign commit         = commit_w;
    assign rf_wen         = commit_w & rec_q.regwrite & (rec_q.wsel != 5'd0);
    assign trk_stall      = ~commit_w;
    assign retire_count   = count_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_memwb_retire_latch.sv
// -----------------------------------------------------------------------------
// tb_memwb_retire_latch
//
// Drives two instances from the same stimulus: one with the default 32-bit
// counter and one with a 4-bit counter for the wrap case. Loaded records are
// pushed to a scoreboard queue and popped when the DUT raises commit.
// -----------------------------------------------------------------------------
module tb_memwb_retire_latch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] target_pc;
        logic [31:0] imm32;
        logic [31:0] wdat;
        logic [31:0] dmem_addr;
        logic [31:0] dmem_store;
        logic [4:0]  rsel1;
        logic [4:0]  rsel2;
        logic [4:0]  wsel;
        logic        regwrite;
        logic        halt;
    } rec_t;

    logic        CLK = 1'b0;
    logic        nRST, en, flush, in_valid;
    logic [31:0] in_instr, in_pc, in_next_pc, in_target_pc, in_imm32, in_wdat;
    logic [31:0] in_dmem_addr, in_dmem_store;
    logic [4:0]  in_rsel1, in_rsel2, in_wsel;
    logic        in_regwrite, in_halt;

    logic [31:0] a_instr, a_pc, a_next_pc, a_target_pc, a_imm32, a_wdat, a_daddr, a_dstore;
    logic [4:0]  a_rsel1, a_rsel2, a_wsel;
    logic        a_regwrite, a_halt, a_valid, a_commit, a_rf_wen, a_trk_stall, a_halted;
    logic [31:0] a_cnt;

    logic [31:0] b_instr, b_pc, b_next_pc, b_target_pc, b_imm32, b_wdat, b_daddr, b_dstore;
    logic [4:0]  b_rsel1, b_rsel2, b_wsel;
    logic        b_regwrite, b_halt, b_valid, b_commit, b_rf_wen, b_trk_stall, b_halted;
    logic [3:0]  b_cnt;

    rec_t a_got, b_got;
    assign a_got = {a_instr, a_pc, a_next_pc, a_target_pc, a_imm32, a_wdat, a_daddr,
                    a_dstore, a_rsel1, a_rsel2, a_wsel, a_regwrite, a_halt};
    assign b_got = {b_instr, b_pc, b_next_pc, b_target_pc, b_imm32, b_wdat, b_daddr,
                    b_dstore, b_rsel1, b_rsel2, b_wsel, b_regwrite, b_halt};

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    memwb_retire_latch dut_a (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .in_next_pc(in_next_pc),
        .in_target_pc(in_target_pc), .in_imm32(in_imm32), .in_wdat(in_wdat),
        .in_dmem_addr(in_dmem_addr), .in_dmem_store(in_dmem_store),
        .in_rsel1(in_rsel1), .in_rsel2(in_rsel2), .in_wsel(in_wsel),
        .in_regwrite(in_regwrite), .in_halt(in_halt),
        .out_instr(a_instr), .out_pc(a_pc), .out_next_pc(a_next_pc),
        .out_target_pc(a_target_pc), .out_imm32(a_imm32), .out_wdat(a_wdat),
        .out_dmem_addr(a_daddr), .out_dmem_store(a_dstore),
        .out_rsel1(a_rsel1), .out_rsel2(a_rsel2), .out_wsel(a_wsel),
        .out_regwrite(a_regwrite), .out_halt(a_halt), .out_valid(a_valid),
        .commit(a_commit), .rf_wen(a_rf_wen), .trk_stall(a_trk_stall),
        .retire_count(a_cnt), .halted(a_halted)
    );

    memwb_retire_latch #(.CNT_W(4)) dut_b (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .in_valid(in_valid),
        .in_instr(in_instr), .in_pc(in_pc), .in_next_pc(in_next_pc),
        .in_target_pc(in_target_pc), .in_imm32(in_imm32), .in_wdat(in_wdat),
        .in_dmem_addr(in_dmem_addr), .in_dmem_store(in_dmem_store),
        .in_rsel1(in_rsel1), .in_rsel2(in_rsel2), .in_wsel(in_wsel),
        .in_regwrite(in_regwrite), .in_halt(in_halt),
        .out_instr(b_instr), .out_pc(b_pc), .out_next_pc(b_next_pc),
        .out_target_pc(b_target_pc), .out_imm32(b_imm32), .out_wdat(b_wdat),
        .out_dmem_addr(b_daddr), .out_dmem_store(b_dstore),
        .out_rsel1(b_rsel1), .out_rsel2(b_rsel2), .out_wsel(b_wsel),
        .out_regwrite(b_regwrite), .out_halt(b_halt), .out_valid(b_valid),
        .commit(b_commit), .rf_wen(b_rf_wen), .trk_stall(b_trk_stall),
        .retire_count(b_cnt), .halted(b_halted)
    );

    // Builds a full record whose side fields are derived from the pc, so
    // every output word carries a distinct, predictable value.
    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] wsel, input logic rw, input logic hlt);
        rec_t r;
        r.instr      = instr;
        r.pc         = pc;
        r.next_pc    = pc + 32'd4;
        r.target_pc  = pc + 32'h100;
        r.imm32      = pc ^ 32'hA5A5_0000;
        r.wdat       = pc * 32'd3 + 32'd1;
        r.dmem_addr  = pc + 32'h1000;
        r.dmem_store = ~pc;
        r.rsel1      = pc[6:2];
        r.rsel2      = wsel ^ 5'h1f;
        r.wsel       = wsel;
        r.regwrite   = rw;
        r.halt       = hlt;
        return r;
    endfunction

    task automatic drive(input rec_t r, input logic v);
        in_instr      = r.instr;
        in_pc         = r.pc;
        in_next_pc    = r.next_pc;
        in_target_pc  = r.target_pc;
        in_imm32      = r.imm32;
        in_wdat       = r.wdat;
        in_dmem_addr  = r.dmem_addr;
        in_dmem_store = r.dmem_store;
        in_rsel1      = r.rsel1;
        in_rsel2      = r.rsel2;
        in_wsel       = r.wsel;
        in_regwrite   = r.regwrite;
        in_halt       = r.halt;
        in_valid      = v;
        en            = 1'b1;
    endtask

    // Drive a valid record that is expected to be taken and later committed.
    task automatic load(input rec_t r);
        drive(r, 1'b1);
        exp_q.push_back(r);
    endtask

    // Advance one edge, sample 1 time unit later, retire against the scoreboard.
    task automatic tick();
        rec_t e;
        @(posedge CLK);
        #1;
        if (a_commit || b_commit) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit a_pc=%h b_pc=%h", a_pc, b_pc);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (a_commit !== 1'b1 || b_commit !== 1'b1) begin
                    n_fail++;
                    $display("FAIL commit_both got a=%b b=%b want 1", a_commit, b_commit);
                end
                n_checks++;
                if (a_got !== e || a_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL commit_rec_a got %h want %h", a_got, e);
                end
                n_checks++;
                if (b_got !== e) begin
                    n_fail++;
                    $display("FAIL commit_rec_b got %h want %h", b_got, e);
                end
                n_checks++;
                if (a_rf_wen !== (e.regwrite && e.wsel != 5'd0)) begin
                    n_fail++;
                    $display("FAIL commit_rf_wen got %b want %b", a_rf_wen,
                             (e.regwrite && e.wsel != 5'd0));
                end
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; en = 1'b0; flush = 1'b0;
        drive(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b0);
        en = 1'b0;
        #12;
        n_checks++;
        if (a_valid !== 1'b0 || a_commit !== 1'b0 || a_trk_stall !== 1'b1 || a_halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got v=%b c=%b s=%b h=%b want 0 0 1 0",
                     a_valid, a_commit, a_trk_stall, a_halted);
        end
        n_checks++;
        if (a_got !== rec_t'(0) || a_cnt !== 32'd0 || b_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got rec=%h cnt=%0d/%0d want 0", a_got, a_cnt, b_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_single_load();
        load(mk(32'h0000_0004, 32'h0050_0093, 5'd1, 1'b1, 1'b0));
        tick();
        n_checks++;
        if (a_commit !== 1'b1 || a_rf_wen !== 1'b1 || a_pc !== 32'h4 || a_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL single_load got c=%b w=%b pc=%h cnt=%0d want 1 1 4 0",
                     a_commit, a_rf_wen, a_pc, a_cnt);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 32'd1 || b_cnt !== 4'd1 || a_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count got cnt=%0d/%0d c=%b want 1 1 0", a_cnt, b_cnt, a_commit);
        end
    endtask

    task automatic test_stall();
        rec_t r;
        r = mk(32'h0000_0010, 32'h0020_8133, 5'd2, 1'b1, 1'b0);
        load(r);
        tick();
        n_checks++;
        if (a_commit !== 1'b1 || a_trk_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first got c=%b s=%b want 1 0", a_commit, a_trk_stall);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (a_commit !== 1'b0 || a_trk_stall !== 1'b1 || a_got !== r || a_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got c=%b s=%b rec=%h want 0 1 %h",
                         i, a_commit, a_trk_stall, a_got, r);
            end
        end
        n_checks++;
        if (a_cnt !== 32'd2 || b_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL stall_count got %0d/%0d want 2", a_cnt, b_cnt);
        end
    endtask

    task automatic test_flush_priority();
        drive(mk(32'h0000_0020, 32'h0000_0513, 5'd10, 1'b1, 1'b0), 1'b1);
        flush = 1'b1;
        tick();
        n_checks++;
        if (a_valid !== 1'b0 || a_instr !== 32'h0 || a_pc !== 32'h0 || a_commit !== 1'b0 ||
            a_next_pc !== 32'h0 || a_wsel !== 5'd0 || a_regwrite !== 1'b0 || a_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble got v=%b instr=%h pc=%h c=%b want 0 0 0 0",
                     a_valid, a_instr, a_pc, a_commit);
        end
        flush = 1'b0; en = 1'b0;
        tick();
        n_checks++;
        if (a_commit !== 1'b0 || a_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL flush_after got c=%b cnt=%0d want 0 2", a_commit, a_cnt);
        end
    endtask

    task automatic test_x0_write();
        load(mk(32'h0000_0024, 32'h0010_0013, 5'd0, 1'b1, 1'b0));
        tick();
        n_checks++;
        if (a_commit !== 1'b1 || a_rf_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_write got c=%b w=%b want 1 0", a_commit, a_rf_wen);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL x0_count got %0d want 3", a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            load(mk(32'h30 + 32'(4 * i), 32'h0000_0013 | (32'(i + 1) << 7),
                    5'(i + 3), 1'b1, 1'b0));
            tick();
            n_checks++;
            if (a_commit !== 1'b1 || a_cnt !== 32'(3 + i)) begin
                n_fail++;
                $display("FAIL b2b_%0d got c=%b cnt=%0d want 1 %0d", i, a_commit, a_cnt, 3 + i);
            end
        end
        // Loading an invalid record writes a bubble that never commits.
        drive(mk(32'h0000_0099, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0), 1'b0);
        tick();
        n_checks++;
        if (a_valid !== 1'b0 || a_commit !== 1'b0 || a_instr !== 32'h0 || a_cnt !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_bubble got v=%b c=%b instr=%h cnt=%0d want 0 0 0 6",
                     a_valid, a_commit, a_instr, a_cnt);
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        rec_t h;
        load(mk(32'h0000_003c, 32'h0000_0013, 5'd5, 1'b1, 1'b0));
        tick();
        h = mk(32'h0000_0040, 32'h0010_0073, 5'd0, 1'b0, 1'b1);
        load(h);
        tick();
        n_checks++;
        if (a_commit !== 1'b1 || a_halted !== 1'b0 || a_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL halt_commit got c=%b h=%b cnt=%0d want 1 0 7", a_commit, a_halted, a_cnt);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (a_halted !== 1'b1 || a_commit !== 1'b0 || a_cnt !== 32'd8 || b_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL halt_set got h=%b c=%b cnt=%0d/%0d want 1 0 8",
                     a_halted, a_commit, a_cnt, b_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h50 + 32'(4 * i), 32'h0000_0093, 5'd1, 1'b1, 1'b0), 1'b1);
            flush = (i == 1);
            tick();
            n_checks++;
            if (a_commit !== 1'b0 || a_got !== h || a_valid !== 1'b1 ||
                a_halted !== 1'b1 || a_cnt !== 32'd8) begin
                n_fail++;
                $display("FAIL halt_frozen%0d got c=%b rec=%h h=%b cnt=%0d want 0 %h 1 8",
                         i, a_commit, a_got, a_halted, a_cnt, h);
            end
        end
        flush = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_mid_halt();
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (a_halted !== 1'b0 || a_valid !== 1'b0 || a_cnt !== 32'd0 ||
            b_cnt !== 4'd0 || a_commit !== 1'b0 || a_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_halt got h=%b v=%b cnt=%0d/%0d c=%b want 0 0 0 0",
                     a_halted, a_valid, a_cnt, b_cnt, a_commit);
        end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        n_checks++;
        if (a_commit !== 1'b0 || a_valid !== 1'b0 || a_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_halt_after got c=%b v=%b cnt=%0d want 0 0 0",
                     a_commit, a_valid, a_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 16; i++) begin
            load(mk(32'h100 + 32'(4 * i), 32'h0000_0013, 5'(i + 1), 1'b1, 1'b0));
            tick();
        end
        n_checks++;
        if (b_cnt !== 4'd15 || a_cnt !== 32'd15) begin
            n_fail++;
            $display("FAIL wrap_pre got %0d/%0d want 15 15", a_cnt, b_cnt);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (b_cnt !== 4'd0 || a_cnt !== 32'd16 || a_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap got a=%0d b=%0d c=%b want 16 0 0", a_cnt, b_cnt, a_commit);
        end
    endtask

    task automatic test_reset_mid_stall();
        load(mk(32'h0000_0200, 32'h0040_0113, 5'd2, 1'b1, 1'b0));
        tick();
        en = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 32'd17 || b_cnt !== 4'd1 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_pre_reset got %0d/%0d v=%b want 17 1 1", a_cnt, b_cnt, a_valid);
        end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (a_valid !== 1'b0 || a_cnt !== 32'd0 || b_cnt !== 4'd0 || a_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stall got v=%b cnt=%0d/%0d pc=%h want 0 0 0 0",
                     a_valid, a_cnt, b_cnt, a_pc);
        end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        n_checks++;
        if (a_commit !== 1'b0 || a_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_after got c=%b cnt=%0d want 0 0", a_commit, a_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_load();
        test_stall();
        test_flush_priority();
        test_x0_write();
        test_back_to_back();
        test_halt();
        test_reset_mid_halt();
        test_counter_wrap();
        test_reset_mid_stall();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
